// File: rtl/mio_dm_responder.sv
// Data-memory responder for the CPU MIO bus: captures a request, waits a programmable
// number of cycles, then performs a lane-merged store or an extended load and pulses MIO_ready.
//
// state  | meaning
// S_IDLE | waiting for CPU_MIO; request fields captured on the accepting edge
// S_WAIT | counting down wait states; access performed on the edge where counter==0
// S_RESP | MIO_ready high for this single cycle, then back to S_IDLE
module mio_dm_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CPU_MIO,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_in,
   input  logic [2:0]  dm_ctrl,
   output logic [31:0] Data_out,
   output logic        MIO_ready,
   output logic        mem_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        capture, access;

   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  ctrl_q;

   logic [31:0] mem [DEPTH];

   logic [AW-1:0] idx;
   logic          in_range;
   logic [31:0]   rd_word;
   logic [15:0]   half_v;
   logic [7:0]    byte_v;
   logic [31:0]   load_c;
   logic [3:0]    wmask;
   logic [31:0]   lane_data;
   logic [31:0]   bitmask;
   logic [31:0]   merged;
   logic          err_c;
   logic          wr_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture   = 1'b0;
      access    = 1'b0;
      MIO_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (CPU_MIO) begin
               capture = 1'b1;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access  = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            MIO_ready = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign idx      = addr_q[AW+1:2];
   assign in_range = (addr_q[31:2] < 30'(DEPTH));
   assign rd_word  = mem[idx];
   assign half_v   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_v = rd_word[7:0];
         2'd1:    byte_v = rd_word[15:8];
         2'd2:    byte_v = rd_word[23:16];
         default: byte_v = rd_word[31:24];
      endcase
   end

   // Decode of the captured request: lane mask, replicated store data, load extension, error.
   always_comb begin
      load_c    = 32'd0;
      wmask     = 4'b0000;
      lane_data = wdata_q;
      err_c     = 1'b0;
      case (ctrl_q)
         3'b000: begin
            err_c  = (addr_q[1:0] != 2'b00);
            wmask  = 4'b1111;
            load_c = rd_word;
         end
         3'b001, 3'b010: begin
            err_c     = addr_q[0];
            wmask     = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
            load_c    = {{16{(ctrl_q == 3'b001) & half_v[15]}}, half_v};
         end
         3'b011, 3'b100: begin
            wmask     = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
            load_c    = {{24{(ctrl_q == 3'b011) & byte_v[7]}}, byte_v};
         end
         default: err_c = 1'b1;
      endcase
      if (!in_range) begin
         err_c = 1'b1;
      end
   end

   assign bitmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
   assign merged  = (rd_word & ~bitmask) | (lane_data & bitmask);
   assign wr_en   = access & we_q & ~err_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         Data_out <= 32'd0;
         mem_err  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         ctrl_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            we_q    <= mem_w;
            addr_q  <= Addr_in;
            wdata_q <= Data_in;
            ctrl_q  <= dm_ctrl;
         end
         if (access) begin
            Data_out <= (we_q || err_c) ? 32'd0 : load_c;
            mem_err  <= err_c;
         end
      end
   end

   // RAM is deliberately not reset; write only fires from S_WAIT, so reset aborts pending stores.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= merged;
      end
   end

endmodule

// File: tb/tb_mio_dm_responder.sv
// Self-checking bench for mio_dm_responder: scoreboard of expected responses,
// popped when MIO_ready pulses, plus latency, pulse-width, hold and reset checks.
module tb_mio_dm_responder;

   localparam int DEPTH       = 1024;
   localparam int WAIT_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        CPU_MIO = 1'b0;
   logic        mem_w = 1'b0;
   logic [31:0] Addr_in = 32'd0;
   logic [31:0] Data_in = 32'd0;
   logic [2:0]  dm_ctrl = 3'd0;
   logic [31:0] Data_out;
   logic        MIO_ready;
   logic        mem_err;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   mio_dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w), .Addr_in(Addr_in),
      .Data_in(Data_in), .dm_ctrl(dm_ctrl), .Data_out(Data_out),
      .MIO_ready(MIO_ready), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] c, input logic [31:0] ed, input logic ee,
                       input string name);
      exp_t e;
      int   n;
      bit   seen;
      e.data = ed;
      e.err  = ee;
      sb.push_back(e);
      mem_w = w; Addr_in = a; Data_in = d; dm_ctrl = c; CPU_MIO = 1'b1;
      @(posedge clk);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (MIO_ready) seen = 1'b1;
      end
      CPU_MIO = 1'b0;
      n_checks++;
      if (!seen) begin
         $display("FAIL %s timeout: no MIO_ready after %0d cycles", name, n);
         void'(sb.pop_front());
      end else begin
         n_pass++;
         e = sb.pop_front();
         n_checks++;
         if (n !== WAIT_CYCLES + 1) $display("FAIL %s latency: got %0d expected %0d", name, n, WAIT_CYCLES + 1);
         else n_pass++;
         n_checks++;
         if (Data_out !== e.data) $display("FAIL %s data: got %h expected %h", name, Data_out, e.data);
         else n_pass++;
         n_checks++;
         if (mem_err !== e.err) $display("FAIL %s mem_err: got %b expected %b", name, mem_err, e.err);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if (MIO_ready !== 1'b0 || Data_out !== e.data)
            $display("FAIL %s pulse/hold: ready %b data %h expected ready 0 data %h", name, MIO_ready, Data_out, e.data);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      int pulses;
      @(negedge clk);
      n_checks++;
      if ({MIO_ready, mem_err, Data_out} !== 34'd0)
         $display("FAIL reset_outputs: ready %b err %b data %h expected all 0", MIO_ready, mem_err, Data_out);
      else n_pass++;
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (MIO_ready) pulses++;
      end
      n_checks++;
      if (pulses !== 0) $display("FAIL idle_no_req: got %0d pulses expected 0", pulses);
      else n_pass++;
   endtask

   task automatic test_word();
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0, 1'b0, "st_word_10");
      xfer(1'b0, 32'h10, 32'h0, 3'b000, 32'hDEADBEEF, 1'b0, "ld_word_10");
   endtask

   task automatic test_byte();
      xfer(1'b1, 32'h11, 32'hABCDEF80, 3'b011, 32'h0, 1'b0, "st_byte_11");
      xfer(1'b0, 32'h11, 32'h0, 3'b011, 32'hFFFFFF80, 1'b0, "ld_byte_11");
      xfer(1'b0, 32'h11, 32'h0, 3'b100, 32'h00000080, 1'b0, "ld_ubyte_11");
      xfer(1'b0, 32'h10, 32'h0, 3'b000, 32'hDEAD80EF, 1'b0, "ld_word_after_byte");
   endtask

   task automatic test_half();
      xfer(1'b1, 32'h12, 32'h55558001, 3'b001, 32'h0, 1'b0, "st_half_12");
      xfer(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, "ld_half_12");
      xfer(1'b0, 32'h12, 32'h0, 3'b010, 32'h00008001, 1'b0, "ld_uhalf_12");
      xfer(1'b0, 32'h10, 32'h0, 3'b000, 32'h800180EF, 1'b0, "ld_word_after_half");
   endtask

   task automatic test_errors();
      xfer(1'b1, 32'h0, 32'h11111111, 3'b000, 32'h0, 1'b0, "st_word_0");
      xfer(1'b0, 32'h13, 32'h0, 3'b000, 32'h0, 1'b1, "err_ld_word_13");
      xfer(1'b1, 32'h11, 32'hFFFF, 3'b001, 32'h0, 1'b1, "err_st_half_11");
      xfer(1'b0, 32'h10, 32'h0, 3'b111, 32'h0, 1'b1, "err_ctrl_111");
      xfer(1'b1, 32'h10, 32'h0, 3'b101, 32'h0, 1'b1, "err_st_ctrl_101");
      xfer(1'b0, 32'(4 * DEPTH), 32'h0, 3'b000, 32'h0, 1'b1, "err_ld_range");
      xfer(1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0, 3'b000, 32'h0, 1'b1, "err_st_range");
      xfer(1'b0, 32'h10, 32'h0, 3'b000, 32'h800180EF, 1'b0, "ld_word_10_unchanged");
      xfer(1'b0, 32'h0, 32'h0, 3'b000, 32'h11111111, 1'b0, "ld_word_0_unchanged");
   endtask

   task automatic test_back_to_back();
      xfer(1'b1, 32'h40, 32'h01234567, 3'b000, 32'h0, 1'b0, "b2b_st_40");
      xfer(1'b1, 32'h44, 32'h89ABCDEF, 3'b000, 32'h0, 1'b0, "b2b_st_44");
      xfer(1'b0, 32'h40, 32'h0, 3'b000, 32'h01234567, 1'b0, "b2b_ld_40");
      xfer(1'b0, 32'h47, 32'h0, 3'b100, 32'h00000089, 1'b0, "b2b_ld_ubyte_47");
      xfer(1'b0, 32'h46, 32'h0, 3'b001, 32'hFFFF89AB, 1'b0, "b2b_ld_half_46");
      xfer(1'b0, 32'h44, 32'h0, 3'b010, 32'h0000CDEF, 1'b0, "b2b_ld_uhalf_44");
      xfer(1'b0, 32'h40, 32'h0, 3'b011, 32'h00000067, 1'b0, "b2b_ld_byte_40");
   endtask

   task automatic test_hold();
      exp_t e;
      int   pulses;
      e.data = 32'h800180EF;
      e.err  = 1'b0;
      sb.push_back(e);
      mem_w = 1'b0; Addr_in = 32'h10; Data_in = 32'h0; dm_ctrl = 3'b000; CPU_MIO = 1'b1;
      @(posedge clk);
      @(negedge clk);
      CPU_MIO = 1'b0; mem_w = 1'b1; Addr_in = 32'h44; Data_in = $urandom; dm_ctrl = 3'b111;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (MIO_ready) begin
            pulses++;
            if (pulses == 1) begin
               e = sb.pop_front();
               n_checks++;
               if (Data_out !== e.data || mem_err !== e.err)
                  $display("FAIL hold_resp: data %h err %b expected %h %b", Data_out, mem_err, e.data, e.err);
               else n_pass++;
            end
         end
      end
      if (pulses == 0) void'(sb.pop_front());
      n_checks++;
      if (pulses !== 1) $display("FAIL hold_pulses: got %0d expected 1", pulses);
      else n_pass++;
      xfer(1'b0, 32'h44, 32'h0, 3'b000, 32'h89ABCDEF, 1'b0, "hold_44_unchanged");
   endtask

   task automatic test_reset_mid();
      int pulses;
      xfer(1'b1, 32'h20, 32'h0, 3'b000, 32'h0, 1'b0, "st_word_20_zero");
      xfer(1'b0, 32'h10, 32'h0, 3'b000, 32'h800180EF, 1'b0, "ld_before_abort");
      mem_w = 1'b1; Addr_in = 32'h20; Data_in = 32'hCAFEF00D; dm_ctrl = 3'b000; CPU_MIO = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      CPU_MIO = 1'b0;
      #1;
      n_checks++;
      if ({MIO_ready, mem_err, Data_out} !== 34'd0)
         $display("FAIL abort_reset: ready %b err %b data %h expected all 0", MIO_ready, mem_err, Data_out);
      else n_pass++;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (MIO_ready) pulses++;
      end
      n_checks++;
      if (pulses !== 0) $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      xfer(1'b0, 32'h20, 32'h0, 3'b000, 32'h0, 1'b0, "ld_word_20_after_abort");
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
